// File: rtl/btn_pkg.sv
// Shared constants, repeat-FSM state type and width helpers for the button conditioner.
package btn_pkg;

    localparam int unsigned NUM_BTNS = 5;

    localparam int unsigned BTN_U = 0;
    localparam int unsigned BTN_D = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_C = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Counter width able to hold 0..n with headroom for saturation.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce counter, press edge and optional auto-repeat.
// The auto-repeat FSM is built only when BTN_AUTOREPEAT_EN is defined and REPEAT_EN is set.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_PERIOD   = 3750000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_c
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || (REPEAT_EN && (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0))) begin : g_bad_cfg
        $error("btn_channel: illegal timing parameters");
    end

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            db_done_c;
    logic            level_nxt_c;
    logic            rise_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept the new value only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_done_c   = (sync2 != level) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        level_nxt_c = db_done_c ? sync2 : level;
        rise_c      = level_nxt_c & ~level;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else begin
            if (sync2 == level || db_done_c) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            level <= level_nxt_c;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic rpt_pulse_c;

    if (REPEAT_EN) begin : g_rpt
        localparam int unsigned CNT_W = max_u(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_PERIOD));

        rpt_state_t       state;
        rpt_state_t       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] cnt_inc_c;
        logic             pulse_c;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // A release seen on the debounced level drops straight back to IDLE.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pulse_c   = 1'b0;
            cnt_inc_c = (&cnt) ? cnt : cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (rise_c) begin
                        state_nxt = DELAY;
                        cnt_nxt   = '0;
                    end
                end
                DELAY: begin
                    if (!level_nxt_c) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                        pulse_c   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc_c;
                    end
                end
                REPEAT: begin
                    if (!level_nxt_c) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                        cnt_nxt = '0;
                        pulse_c = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc_c;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign rpt_pulse_c = pulse_c;
    end else begin : g_no_rpt
        assign rpt_pulse_c = 1'b0;
    end

    assign press_c = rise_c | rpt_pulse_c;
`else
    assign press_c = rise_c;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            press <= 1'b0;
        end else begin
            press <= press_c;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: per-button debounce, press pulses and (with BTN_AUTOREPEAT_EN)
// auto-repeat on every button except centre.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_PERIOD   = 3750000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic                any_press
);

    logic [NUM_BTNS-1:0] press_c;

    for (genvar i = 0; i < int'(NUM_BTNS); i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (i != int'(BTN_C))
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i]),
            .press_c (press_c[i])
        );
    end

    // Registered from the same next-cycle pulses so it lines up with btn_press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_c;
        end
    end

endmodule
